sqrt_share_ctrl: RTL

Controller that shares one 32/16-bit iterative restoring square-root unit between two requesters, e.g. the integer pipe and the FPU-assist path. It arbitrates round-robin and loads the unit with a single-cycle load pulse. It tracks the unit's 16-iteration busy window, latches root and remainder, and returns them to the owning requester through a valid/ack handshake. It also supports per-requester flush and a watchdog timeout.

---
 rtl/sqrt_share_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sqrt_share_ctrl.sv
// rtl/sqrt_share_ctrl.sv - two-requester round-robin controller for a shared iterative sqrt unit
module sqrt_share_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ROOT_W  = DATA_W / 2,
  parameter int TIMEOUT = 24
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [1:0]        i_req,
  input  logic [DATA_W-1:0] i_req_d0,
  input  logic [DATA_W-1:0] i_req_d1,
  output logic [1:0]        o_req_ack,
  input  logic [1:0]        i_flush,
  output logic [1:0]        o_resp_valid,
  input  logic [1:0]        i_resp_ack,
  output logic [ROOT_W-1:0] o_resp_q,
  output logic [ROOT_W:0]   o_resp_r,
  output logic              o_timeout_err,
  output logic              o_sq_resetn,
  output logic              o_sq_load,
  output logic [DATA_W-1:0] o_sq_d,
  input  logic              i_sq_busy,
  input  logic              i_sq_ready,
  input  logic [ROOT_W-1:0] i_sq_q,
  input  logic [ROOT_W:0]   i_sq_r
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_ptr;
  logic              r_owner;
  logic              r_killed;
  logic [WD_W-1:0]   r_wdog;
  logic [DATA_W-1:0] r_sq_d;
  logic [ROOT_W-1:0] r_resp_q;
  logic [ROOT_W:0]   r_resp_r;
  logic              r_timeout;

  logic [1:0]        w_elig;
  logic              w_grant;
  logic              w_owner_flush;
  logic              w_owner_ack;
  logic              w_wdog_exp;
  logic              w_drop;

  // A flushed requester is not eligible; the pointer only breaks ties.
  assign w_elig        = i_req & ~i_flush;
  assign w_grant       = (&w_elig) ? r_ptr : w_elig[1];
  assign w_owner_flush = i_flush[r_owner];
  assign w_owner_ack   = i_resp_ack[r_owner];
  assign w_wdog_exp    = (r_wdog == WD_LAST);
  // Result of a killed op is thrown away, including a flush landing with sq_ready.
  assign w_drop        = r_killed | w_owner_flush;

  assign o_sq_resetn   = ~i_reset;
  assign o_sq_d        = r_sq_d;
  assign o_resp_q      = r_resp_q;
  assign o_resp_r      = r_resp_r;
  assign o_timeout_err = r_timeout;

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state: ISSUE waits out a still-busy unit so a load never overlaps a run.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|w_elig) w_next = S_ISSUE;
      S_ISSUE: if (!i_sq_busy) w_next = S_WAIT;
      S_WAIT: begin
        if (i_sq_ready)      w_next = w_drop ? S_IDLE : S_HOLD;
        else if (w_wdog_exp) w_next = S_IDLE;
      end
      S_HOLD:  if (w_owner_flush || w_owner_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ack is held low while reset is asserted.
  always_comb begin
    o_req_ack    = '0;
    o_sq_load    = 1'b0;
    o_resp_valid = '0;
    case (r_state)
      S_IDLE:  if ((|w_elig) && !i_reset) o_req_ack[w_grant] = 1'b1;
      S_ISSUE: o_sq_load = ~i_sq_busy;
      S_HOLD:  o_resp_valid[r_owner] = 1'b1;
      default: ;
    endcase
  end

  // Datapath: grant capture, kill tracking, watchdog and result latch.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_killed  <= 1'b0;
      r_wdog    <= '0;
      r_sq_d    <= '0;
      r_resp_q  <= '0;
      r_resp_r  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_next == S_IDLE) begin
        r_killed <= 1'b0;
      end else if ((r_state == S_ISSUE || r_state == S_WAIT) && w_owner_flush) begin
        r_killed <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_owner <= w_grant;
            r_sq_d  <= w_grant ? i_req_d1 : i_req_d0;
            r_ptr   <= ~w_grant;
          end
        end
        S_ISSUE: r_wdog <= '0;
        S_WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          if (i_sq_ready) begin
            if (!w_drop) begin
              r_resp_q <= i_sq_q;
              r_resp_r <= i_sq_r;
            end
          end else if (w_wdog_exp) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
